// File: rtl/argon_pkg.sv
// Shared pipeline widths and word/index types for the argon core.
package argon_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/operand_bypass.sv
// One-operand forwarding mux: resolves the read-pending value and flags a same-cycle write hit.
module operand_bypass
    import argon_pkg::*;
#(
    parameter int XLEN       = argon_pkg::XLEN,
    parameter int REG_ADDR_W = argon_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] idx_i,
    input  logic [XLEN-1:0]       rf_i,
    input  logic                  fwd_i,
    input  logic [XLEN-1:0]       fwd_data_i,
    input  logic                  wb_en_i,
    input  logic [REG_ADDR_W-1:0] wb_sel_i,
    input  logic [XLEN-1:0]       wb_data_i,
    output logic [XLEN-1:0]       s1_val_o,
    output logic                  wb_hit_o
);
    logic idx_zero;

    assign idx_zero = (idx_i == '0);

    // x0 reads as zero regardless of what the register file or forward path say.
    assign s1_val_o = idx_zero ? '0 : (fwd_i ? fwd_data_i : rf_i);
    assign wb_hit_o = wb_en_i && (wb_sel_i == idx_i) && !idx_zero;
endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: read-pending slot S1 feeding output slot S2, with write-port snooping.
module operand_fetch
    import argon_pkg::*;
#(
    parameter int XLEN       = argon_pkg::XLEN,
    parameter int REG_ADDR_W = argon_pkg::REG_ADDR_W,
    parameter int CTRL_W     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [CTRL_W-1:0]     i_ctrl,
    output logic [REG_ADDR_W-1:0] o_sel_a,
    output logic [REG_ADDR_W-1:0] o_sel_b,
    input  logic [XLEN-1:0]       i_rf_a,
    input  logic [XLEN-1:0]       i_rf_b,
    input  logic                  i_wb_en,
    input  logic [REG_ADDR_W-1:0] i_wb_sel,
    input  logic [XLEN-1:0]       i_wb_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [XLEN-1:0]       o_rs1_val,
    output logic [XLEN-1:0]       o_rs2_val,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [CTRL_W-1:0]     o_ctrl
);
    logic                  v1_q, v1_d;
    logic [REG_ADDR_W-1:0] rs1_1_q, rs1_1_d, rs2_1_q, rs2_1_d, rd_1_q, rd_1_d;
    logic [CTRL_W-1:0]     ctrl_1_q, ctrl_1_d;
    logic                  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [XLEN-1:0]       fwd_data_a_q, fwd_data_a_d, fwd_data_b_q, fwd_data_b_d;
    logic                  v2_q, v2_d;
    logic [XLEN-1:0]       rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
    logic [REG_ADDR_W-1:0] rs1_2_q, rs1_2_d, rs2_2_q, rs2_2_d, rd_2_q, rd_2_d;
    logic [CTRL_W-1:0]     ctrl_2_q, ctrl_2_d;

    logic            move_out, move_12, accept;
    logic [XLEN-1:0] s1_a, s1_b;
    logic            hit_a, hit_b, hold_hit_a, hold_hit_b;

    assign move_out = v2_q && i_ready;
    assign move_12  = v1_q && (!v2_q || i_ready);
    assign o_ready  = !i_reset && (!v1_q || move_12);
    assign accept   = i_valid && o_ready;

    // A stalled S1 keeps presenting its own indices, so the register file re-reads them every cycle.
    assign o_sel_a = i_reset ? '0 : (accept ? i_rs1 : rs1_1_q);
    assign o_sel_b = i_reset ? '0 : (accept ? i_rs2 : rs2_1_q);

    operand_bypass #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_bypass_a (
        .idx_i(rs1_1_q), .rf_i(i_rf_a), .fwd_i(fwd_a_q), .fwd_data_i(fwd_data_a_q),
        .wb_en_i(i_wb_en), .wb_sel_i(i_wb_sel), .wb_data_i(i_wb_data),
        .s1_val_o(s1_a), .wb_hit_o(hit_a)
    );

    operand_bypass #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_bypass_b (
        .idx_i(rs2_1_q), .rf_i(i_rf_b), .fwd_i(fwd_b_q), .fwd_data_i(fwd_data_b_q),
        .wb_en_i(i_wb_en), .wb_sel_i(i_wb_sel), .wb_data_i(i_wb_data),
        .s1_val_o(s1_b), .wb_hit_o(hit_b)
    );

    assign hold_hit_a = i_wb_en && (i_wb_sel == rs1_2_q) && (rs1_2_q != '0);
    assign hold_hit_b = i_wb_en && (i_wb_sel == rs2_2_q) && (rs2_2_q != '0);

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        v1_d         = v1_q;
        rs1_1_d      = rs1_1_q;
        rs2_1_d      = rs2_1_q;
        rd_1_d       = rd_1_q;
        ctrl_1_d     = ctrl_1_q;
        v2_d         = v2_q;
        rs1_val_d    = rs1_val_q;
        rs2_val_d    = rs2_val_q;
        rs1_2_d      = rs1_2_q;
        rs2_2_d      = rs2_2_q;
        rd_2_d       = rd_2_q;
        ctrl_2_d     = ctrl_2_q;

        // Same-edge write: the register file returns the old word, so remember the new one.
        fwd_a_d      = i_wb_en && (i_wb_sel == o_sel_a) && (o_sel_a != '0);
        fwd_b_d      = i_wb_en && (i_wb_sel == o_sel_b) && (o_sel_b != '0);
        fwd_data_a_d = i_wb_data;
        fwd_data_b_d = i_wb_data;

        if (accept) begin
            v1_d     = 1'b1;
            rs1_1_d  = i_rs1;
            rs2_1_d  = i_rs2;
            rd_1_d   = i_rd;
            ctrl_1_d = i_ctrl;
        end else if (move_12) begin
            v1_d = 1'b0;
        end

        if (move_12) begin
            v2_d      = 1'b1;
            rs1_val_d = hit_a ? i_wb_data : s1_a;
            rs2_val_d = hit_b ? i_wb_data : s1_b;
            rs1_2_d   = rs1_1_q;
            rs2_2_d   = rs2_1_q;
            rd_2_d    = rd_1_q;
            ctrl_2_d  = ctrl_1_q;
        end else if (move_out) begin
            v2_d = 1'b0;
        end else if (v2_q) begin
            if (hold_hit_a) rs1_val_d = i_wb_data;
            if (hold_hit_b) rs2_val_d = i_wb_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // NOTE: sequential state uses <= so all registers update together from pre-edge values.
            v1_q         <= 1'b0;
            rs1_1_q      <= '0;
            rs2_1_q      <= '0;
            rd_1_q       <= '0;
            ctrl_1_q     <= '0;
            fwd_a_q      <= 1'b0;
            fwd_b_q      <= 1'b0;
            fwd_data_a_q <= '0;
            fwd_data_b_q <= '0;
            v2_q         <= 1'b0;
            rs1_val_q    <= '0;
            rs2_val_q    <= '0;
            rs1_2_q      <= '0;
            rs2_2_q      <= '0;
            rd_2_q       <= '0;
            ctrl_2_q     <= '0;
        end else begin
            v1_q         <= v1_d;
            rs1_1_q      <= rs1_1_d;
            rs2_1_q      <= rs2_1_d;
            rd_1_q       <= rd_1_d;
            ctrl_1_q     <= ctrl_1_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            fwd_data_a_q <= fwd_data_a_d;
            fwd_data_b_q <= fwd_data_b_d;
            v2_q         <= v2_d;
            rs1_val_q    <= rs1_val_d;
            rs2_val_q    <= rs2_val_d;
            rs1_2_q      <= rs1_2_d;
            rs2_2_q      <= rs2_2_d;
            rd_2_q       <= rd_2_d;
            ctrl_2_q     <= ctrl_2_d;
        end
    end

    assign o_valid   = v2_q;
    assign o_rs1_val = rs1_val_q;
    assign o_rs2_val = rs2_val_q;
    assign o_rd      = rd_2_q;
    assign o_ctrl    = ctrl_2_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vectors, stall/stream/reset sequences, random traffic vs a register-file model.
module tb_operand_fetch;
    import argon_pkg::*;

    localparam int CTRL_W = 16;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_valid;
    logic              o_ready;
    reg_idx_t          i_rs1, i_rs2, i_rd;
    logic [CTRL_W-1:0] i_ctrl;
    reg_idx_t          o_sel_a, o_sel_b;
    word_t             i_rf_a = '0, i_rf_b = '0;
    logic              i_wb_en;
    reg_idx_t          i_wb_sel;
    word_t             i_wb_data;
    logic              o_valid;
    logic              i_ready;
    word_t             o_rs1_val, o_rs2_val;
    reg_idx_t          o_rd;
    logic [CTRL_W-1:0] o_ctrl;

    always #5 i_clk = ~i_clk;

    operand_fetch #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .CTRL_W(CTRL_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_ctrl(i_ctrl),
        .o_sel_a(o_sel_a), .o_sel_b(o_sel_b), .i_rf_a(i_rf_a), .i_rf_b(i_rf_b),
        .i_wb_en(i_wb_en), .i_wb_sel(i_wb_sel), .i_wb_data(i_wb_data),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_rs1_val(o_rs1_val), .o_rs2_val(o_rs2_val), .o_rd(o_rd), .o_ctrl(o_ctrl)
    );

    // Architectural register file: registered reads return the pre-write word on a same-edge write.
    word_t regs [32] = '{default: '0};

    always @(posedge i_clk) begin
        i_rf_a <= regs[o_sel_a];
        i_rf_b <= regs[o_sel_b];
        if (i_wb_en && i_wb_sel != '0) regs[i_wb_sel] <= i_wb_data;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic word_t arch_val(input reg_idx_t idx);
        return (idx == '0) ? '0 : regs[idx];
    endfunction

    task automatic drive_idle();
        i_valid   = 1'b0;
        i_rs1     = '0;
        i_rs2     = '0;
        i_rd      = '0;
        i_ctrl    = '0;
        i_wb_en   = 1'b0;
        i_wb_sel  = '0;
        i_wb_data = '0;
        i_ready   = 1'b1;
    endtask

    task automatic drive_issue(input reg_idx_t rs1, input reg_idx_t rs2, input reg_idx_t rd,
                               input logic [CTRL_W-1:0] ctrl);
        i_valid = 1'b1;
        i_rs1   = rs1;
        i_rs2   = rs2;
        i_rd    = rd;
        i_ctrl  = ctrl;
    endtask

    task automatic drive_wb(input logic en, input reg_idx_t sel, input word_t data);
        i_wb_en   = en;
        i_wb_sel  = sel;
        i_wb_data = data;
    endtask

    // Directed single-instruction vectors; wb_mode 0 = no write, 1 = write in issue cycle, 2 = write in S1 cycle.
    typedef struct {
        reg_idx_t          rs1, rs2, rd;
        logic [CTRL_W-1:0] ctrl;
        int                wb_mode;
        reg_idx_t          wb_sel;
        word_t             wb_data;
        word_t             exp1, exp2;
    } vec_t;

    typedef struct {
        reg_idx_t          rs1, rs2, rd;
        logic [CTRL_W-1:0] ctrl;
    } inst_t;

    inst_t inflight [$];

    task automatic rand_cycle(input bit drain);
        inst_t n;
        if (o_valid) begin
            if (inflight.size() == 0) begin
                check("rand_spurious_valid", 1, 0);
            end else begin
                check("rand_rd",   o_rd,      inflight[0].rd);
                check("rand_ctrl", o_ctrl,    inflight[0].ctrl);
                check("rand_rs1",  o_rs1_val, arch_val(inflight[0].rs1));
                check("rand_rs2",  o_rs2_val, arch_val(inflight[0].rs2));
            end
        end
        if (drain) begin
            drive_idle();
        end else begin
            drive_issue(reg_idx_t'($urandom_range(0, 7)), reg_idx_t'($urandom_range(0, 7)),
                        reg_idx_t'($urandom_range(0, 31)), CTRL_W'($urandom));
            i_valid = ($urandom_range(0, 9) < 7);
            i_ready = ($urandom_range(0, 9) < 7);
            drive_wb(1'($urandom_range(0, 1)), reg_idx_t'($urandom_range(0, 7)), $urandom);
        end
        #1;
        if (o_valid && i_ready && inflight.size() != 0) void'(inflight.pop_front());
        if (i_valid && o_ready) begin
            n = '{rs1: i_rs1, rs2: i_rs2, rd: i_rd, ctrl: i_ctrl};
            inflight.push_back(n);
        end
        @(negedge i_clk);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{rs1: 5, rs2: 0, rd: 9,  ctrl: 16'h0009, wb_mode: 0, wb_sel: 0, wb_data: 32'h0,
                    exp1: 32'h0000_1234, exp2: 32'h0};
        vecs[1] = '{rs1: 7, rs2: 5, rd: 1,  ctrl: 16'h0101, wb_mode: 1, wb_sel: 7, wb_data: 32'hDEAD_BEEF,
                    exp1: 32'hDEAD_BEEF, exp2: 32'h0000_1234};
        vecs[2] = '{rs1: 8, rs2: 8, rd: 2,  ctrl: 16'h0202, wb_mode: 2, wb_sel: 8, wb_data: 32'hCAFE_F00D,
                    exp1: 32'hCAFE_F00D, exp2: 32'hCAFE_F00D};
        vecs[3] = '{rs1: 0, rs2: 0, rd: 3,  ctrl: 16'h0303, wb_mode: 1, wb_sel: 0, wb_data: 32'hFFFF_FFFF,
                    exp1: 32'h0, exp2: 32'h0};
        vecs[4] = '{rs1: 5, rs2: 7, rd: 4,  ctrl: 16'h0404, wb_mode: 2, wb_sel: 5, wb_data: 32'h0000_ABCD,
                    exp1: 32'h0000_ABCD, exp2: 32'hDEAD_BEEF};
        vecs[5] = '{rs1: 31, rs2: 8, rd: 5, ctrl: 16'h0505, wb_mode: 0, wb_sel: 0, wb_data: 32'h0,
                    exp1: 32'h0, exp2: 32'hCAFE_F00D};

        // Reset state, with an instruction offered to show reset blocks acceptance.
        drive_idle();
        i_reset = 1'b1;
        drive_issue(5, 6, 7, 16'h1234);
        repeat (3) @(negedge i_clk);
        #1;
        check("reset_ready",   o_ready,   0);
        check("reset_sel_a",   o_sel_a,   0);
        check("reset_sel_b",   o_sel_b,   0);
        check("reset_valid",   o_valid,   0);
        check("reset_rs1_val", o_rs1_val, 0);
        check("reset_rd",      o_rd,      0);
        check("reset_ctrl",    o_ctrl,    0);
        @(negedge i_clk);
        i_reset = 1'b0;
        drive_idle();

        drive_wb(1, 5, 32'h0000_1234);
        @(negedge i_clk);
        drive_wb(1, 3, 32'h0000_0011);
        @(negedge i_clk);
        drive_idle();
        @(negedge i_clk);

        foreach (vecs[k]) begin
            drive_issue(vecs[k].rs1, vecs[k].rs2, vecs[k].rd, vecs[k].ctrl);
            drive_wb(vecs[k].wb_mode == 1, vecs[k].wb_sel, vecs[k].wb_data);
            #1 check($sformatf("vec%0d_ready", k), o_ready, 1);
            @(negedge i_clk);
            i_valid = 1'b0;
            drive_wb(vecs[k].wb_mode == 2, vecs[k].wb_sel, vecs[k].wb_data);
            check($sformatf("vec%0d_valid_t1", k), o_valid, 0);
            @(negedge i_clk);
            drive_wb(0, 0, 0);
            check($sformatf("vec%0d_valid_t2", k), o_valid, 1);
            check($sformatf("vec%0d_rs1", k),  o_rs1_val, vecs[k].exp1);
            check($sformatf("vec%0d_rs2", k),  o_rs2_val, vecs[k].exp2);
            check($sformatf("vec%0d_rd", k),   o_rd,      vecs[k].rd);
            check($sformatf("vec%0d_ctrl", k), o_ctrl,    vecs[k].ctrl);
            @(negedge i_clk);
        end

        // Downstream stall: A held in S2 for 5 cycles, B stalled in S1, x3 written in hold cycle 2.
        drive_issue(0, 3, 4, 16'hA5A5);
        @(negedge i_clk);
        drive_issue(3, 5, 6, 16'h0B0B);
        @(negedge i_clk);
        for (int h = 1; h <= 5; h++) begin
            i_valid = 1'b0;
            i_ready = 1'b0;
            drive_wb(h == 2, 3, 32'h0000_0055);
            check($sformatf("hold%0d_valid", h), o_valid, 1);
            check($sformatf("hold%0d_rd", h),    o_rd,    4);
            check($sformatf("hold%0d_ctrl", h),  o_ctrl,  16'hA5A5);
            check($sformatf("hold%0d_rs2", h),   o_rs2_val, (h <= 2) ? 32'h11 : 32'h55);
            #1 check($sformatf("hold%0d_ready", h), o_ready, 0);
            @(negedge i_clk);
        end
        drive_idle();
        check("hold_release_rd",  o_rd,      4);
        check("hold_release_rs2", o_rs2_val, 32'h55);
        @(negedge i_clk);
        check("hold_b_valid", o_valid,   1);
        check("hold_b_rd",    o_rd,      6);
        check("hold_b_rs1",   o_rs1_val, 32'h55);
        check("hold_b_rs2",   o_rs2_val, 32'h0000_ABCD);
        @(negedge i_clk);
        check("hold_empty", o_valid, 0);

        // Back-to-back stream: one output per cycle, each reading a register written one cycle before issue.
        drive_wb(1, 10, 32'h0000_100A);
        @(negedge i_clk);
        for (int c = 0; c < 10; c++) begin
            if (c >= 2) begin
                check($sformatf("stream%0d_valid", c - 2), o_valid, 1);
                check($sformatf("stream%0d_rd", c - 2),    o_rd,    11 + c - 2);
                check($sformatf("stream%0d_rs1", c - 2),   o_rs1_val, 32'h1000 + 10 + c - 2);
            end
            if (c < 8) drive_issue(reg_idx_t'(10 + c), 0, reg_idx_t'(11 + c), CTRL_W'(c));
            else i_valid = 1'b0;
            drive_wb(c < 7, reg_idx_t'(11 + c), word_t'(32'h1000 + 11 + c));
            if (c < 8) #1 check($sformatf("stream%0d_ready", c), o_ready, 1);
            @(negedge i_clk);
        end
        check("stream_empty", o_valid, 0);
        drive_idle();

        // Reset with two instructions in flight.
        drive_issue(5, 7, 12, 16'h1111);
        @(negedge i_clk);
        drive_issue(7, 5, 13, 16'h2222);
        @(negedge i_clk);
        check("rst_pre_valid", o_valid, 1);
        i_reset = 1'b1;
        drive_issue(8, 8, 14, 16'h3333);
        #1;
        check("rst_ready", o_ready, 0);
        check("rst_sel_a", o_sel_a, 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        drive_idle();
        check("rst_valid",   o_valid,   0);
        check("rst_rs1_val", o_rs1_val, 0);
        check("rst_rs2_val", o_rs2_val, 0);
        check("rst_rd",      o_rd,      0);
        check("rst_ctrl",    o_ctrl,    0);
        for (int r = 0; r < 5; r++) begin
            @(negedge i_clk);
            check($sformatf("rst_quiet%0d", r), o_valid, 0);
        end

        // Random traffic against the architectural register file, then a bounded drain.
        for (int n = 0; n < 3000; n++) rand_cycle(1'b0);
        for (int n = 0; n < 10; n++) rand_cycle(1'b1);
        check("drain_queue_empty", inflight.size(), 0);
        check("drain_valid",       o_valid,         0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
